// File: rtl/range_line_fetcher_pkg.sv
// Shared constants, FSM state type and element helper for the range line fetcher.
package range_line_fetcher_pkg;

    localparam int unsigned FULL_WIDTH_DEF = 512;
    localparam int unsigned WIDTH_DEF      = 64;
    localparam int unsigned ELEMS          = FULL_WIDTH_DEF / WIDTH_DEF;
    localparam int unsigned LOG_ELEMS      = $clog2(ELEMS);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    // Element 0 occupies the most significant WIDTH bits of a line.
    function automatic logic [WIDTH_DEF-1:0] elem_sel(input logic [FULL_WIDTH_DEF-1:0] line,
                                                      input int unsigned k);
        return line[FULL_WIDTH_DEF - 1 - k * WIDTH_DEF -: WIDTH_DEF];
    endfunction

endpackage

// File: rtl/range_line_fetcher_line_realigner.sv
// Holds the previous memory line and builds offset-shifted output lines from prev and current.
module line_realigner #(
    parameter int unsigned FULL_WIDTH = 512,
    parameter int unsigned WIDTH      = 64,
    localparam int unsigned OffW      = $clog2(FULL_WIDTH / WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic [OffW-1:0]       off_i,
    input  logic [FULL_WIDTH-1:0] cur_i,
    output logic [FULL_WIDTH-1:0] combine_o,
    output logic [FULL_WIDTH-1:0] flush_o
);
    localparam int unsigned LogW = $clog2(WIDTH);
    localparam int unsigned ShW  = OffW + LogW;
    localparam int unsigned RshW = ShW + 1;

    logic [FULL_WIDTH-1:0] prev_q;
    logic [ShW-1:0]        lsh;
    logic [RshW-1:0]       rsh;

    // Shifting left by off elements moves prev elements off.. to the front; cur fills the tail.
    assign lsh       = {off_i, {LogW{1'b0}}};
    assign rsh       = RshW'(FULL_WIDTH) - RshW'(lsh);
    assign flush_o   = prev_q << lsh;
    assign combine_o = (prev_q << lsh) | (cur_i >> rsh);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else if (capture_i) begin
            prev_q <= cur_i;
        end
    end

endmodule

// File: rtl/range_line_fetcher.sv
// Fetches array elements [start,end) as in-order line reads and writes realigned full lines downstream.
module range_line_fetcher
    import range_line_fetcher_pkg::*;
#(
    parameter int unsigned FULL_WIDTH = FULL_WIDTH_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned IDX_WIDTH  = 32,
    parameter int unsigned LOG_OUTST  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [IDX_WIDTH-1:0]  cmd_start,
    input  logic [IDX_WIDTH-1:0]  cmd_end,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [FULL_WIDTH-1:0] mem_rsp_data,
    output logic                  buf_wrreq,
    output logic [FULL_WIDTH-1:0] buf_wdata,
    output logic                  buf_last,
    output logic [7:0]            buf_bounds,
    input  logic                  buf_full,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned LineElems = FULL_WIDTH / WIDTH;
    localparam int unsigned OffW      = $clog2(LineElems);
    localparam int unsigned CW        = IDX_WIDTH + 1;
    localparam int unsigned LineShift = $clog2(FULL_WIDTH / 8);
    localparam int unsigned OutstW    = LOG_OUTST + 1;

    state_e                state_q;
    logic [OffW-1:0]       off_q;
    logic [CW-1:0]         nin_q, nout_q, req_cnt_q, rsp_cnt_q, emit_cnt_q;
    logic [7:0]            lastb_q, bounds_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [OutstW-1:0]     outst_q;
    logic                  wrreq_q, last_q;
    logic [FULL_WIDTH-1:0] wdata_q;

    logic [CW-1:0] start_w, end_w, n_m1_w, l0_w, l1_w, nin_w, nout_w;
    logic [7:0]    lastb_w;

    always_comb begin
        start_w = CW'(cmd_start);
        end_w   = CW'(cmd_end);
        n_m1_w  = end_w - start_w - CW'(1);
        l0_w    = start_w >> OffW;
        l1_w    = (end_w - CW'(1)) >> OffW;
        nin_w   = l1_w - l0_w + CW'(1);
        nout_w  = (n_m1_w >> OffW) + CW'(1);
        lastb_w = 8'(n_m1_w[OffW-1:0]) + 8'd1;
    end

    logic slot_free, req_fire, rsp_fire, out_fire, rsp_emit, flush_emit, emit, emit_last;
    logic [FULL_WIDTH-1:0] combine_w, flush_w, emit_data;

    assign cmd_ready     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign slot_free     = !wrreq_q || !buf_full;
    assign out_fire      = wrreq_q && !buf_full;
    assign mem_req_valid = (state_q == StRun) && (req_cnt_q < nin_q)
                           && (outst_q < OutstW'(1 << LOG_OUTST));
    assign mem_req_addr  = addr_q;
    assign mem_rsp_ready = (state_q == StRun) && slot_free;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    // With a nonzero offset the first returned line only primes the realigner.
    assign rsp_emit      = rsp_fire && ((off_q == '0) || (rsp_cnt_q != '0));
    assign flush_emit    = (state_q == StFlush) && (emit_cnt_q < nout_q) && slot_free;
    assign emit          = rsp_emit || flush_emit;
    assign emit_last     = (emit_cnt_q == nout_q - CW'(1));
    assign emit_data     = flush_emit ? flush_w : ((off_q == '0) ? mem_rsp_data : combine_w);

    assign buf_wrreq  = wrreq_q;
    assign buf_wdata  = wdata_q;
    assign buf_last   = last_q;
    assign buf_bounds = bounds_q;

    line_realigner #(
        .FULL_WIDTH (FULL_WIDTH),
        .WIDTH      (WIDTH)
    ) u_realign (
        .clk_i     (clk),
        .rst_i     (rst),
        .capture_i (rsp_fire),
        .off_i     (off_q),
        .cur_i     (mem_rsp_data),
        .combine_o (combine_w),
        .flush_o   (flush_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            off_q      <= '0;
            nin_q      <= '0;
            nout_q     <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            emit_cnt_q <= '0;
            lastb_q    <= '0;
            bounds_q   <= '0;
            addr_q     <= '0;
            outst_q    <= '0;
            wrreq_q    <= 1'b0;
            last_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            if (req_fire) begin
                addr_q    <= addr_q + ADDR_WIDTH'(FULL_WIDTH / 8);
                req_cnt_q <= req_cnt_q + CW'(1);
            end
            if (rsp_fire) begin
                rsp_cnt_q <= rsp_cnt_q + CW'(1);
            end
            if (req_fire && !rsp_fire) begin
                outst_q <= outst_q + OutstW'(1);
            end else if (!req_fire && rsp_fire) begin
                outst_q <= outst_q - OutstW'(1);
            end

            if (emit) begin
                wrreq_q    <= 1'b1;
                wdata_q    <= emit_data;
                last_q     <= emit_last;
                bounds_q   <= emit_last ? lastb_q : 8'd0;
                emit_cnt_q <= emit_cnt_q + CW'(1);
            end else if (out_fire) begin
                wrreq_q  <= 1'b0;
                last_q   <= 1'b0;
                bounds_q <= 8'd0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_end <= cmd_start) begin
                            state_q <= StDone;
                        end else begin
                            state_q    <= StRun;
                            off_q      <= cmd_start[OffW-1:0];
                            nin_q      <= nin_w;
                            nout_q     <= nout_w;
                            lastb_q    <= lastb_w;
                            addr_q     <= cmd_addr + (ADDR_WIDTH'(l0_w) << LineShift);
                            req_cnt_q  <= '0;
                            rsp_cnt_q  <= '0;
                            emit_cnt_q <= '0;
                            outst_q    <= '0;
                        end
                    end
                end
                StRun: begin
                    if (out_fire && last_q) begin
                        state_q <= StDone;
                    end else if (rsp_fire && (rsp_cnt_q == nin_q - CW'(1)) && (off_q != '0)
                                 && (nin_q == nout_q)) begin
                        // Tail elements of the final input line still need their own line.
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (out_fire && last_q) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
